// File: rtl/dmem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage data-memory access unit.
// Holds width codes, FSM state encoding, byte-enable constants, the
// latched request and MEM/WB result records, and a helper that builds a result.
package dmem_pkg;

  localparam logic [2:0] W_WORD = 3'b001;
  localparam logic [2:0] W_HALF = 3'b010;
  localparam logic [2:0] W_BYTE = 3'b100;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Memory command held on the bus for the whole REQ phase.
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  // Request fields carried through to the MEM/WB result.
  typedef struct packed {
    logic       load;
    logic [1:0] pos;
    logic [2:0] width;
    logic       sign;
    logic [4:0] rd;
  } req_info_t;

  typedef struct packed {
    logic        valid;
    logic        load;
    logic [31:0] dmem_data;
    logic [1:0]  pos;
    logic [2:0]  width;
    logic        sign;
    logic [4:0]  rd;
    logic        misalign;
    logic        bus_err;
  } out_t;

  function automatic out_t make_out(input req_info_t info, input logic [31:0] data,
                                    input logic misalign, input logic bus_err);
    out_t o;
    o.valid     = 1'b1;
    o.load      = info.load;
    o.dmem_data = data;
    o.pos       = info.pos;
    o.width     = info.width;
    o.sign      = info.sign;
    o.rd        = info.rd;
    o.misalign  = misalign;
    o.bus_err   = bus_err;
    return o;
  endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Data-memory bus between the access unit (master) and memory (slave).
// Latency: none (wires only). Backpressure: mem_req is held until mem_ack.
// Ports: mem_req/we/be/addr/wdata from master, mem_ack/rdata from slave.
interface dmem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmem_access_unit_store_lane_gen.sv
// Maps (width, byte position, store data) to byte enables, lane-replicated data, misalign.
// Latency: combinational. Backpressure: none.
// Ports: width_i/pos_i/wdata_i in; be_o/wdata_o/misalign_o out.
module store_lane_gen
  import dmem_pkg::*;
(
  input  logic [2:0]  width_i,
  input  logic [1:0]  pos_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o
);

  always_comb begin
    be_o       = '0;
    wdata_o    = '0;
    misalign_o = 1'b0;
    case (width_i)
      W_WORD: begin
        be_o       = BE_WORD;
        wdata_o    = wdata_i;
        misalign_o = (pos_i != 2'b00);
      end
      W_HALF: begin
        be_o       = pos_i[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = pos_i[0];
      end
      W_BYTE: begin
        be_o    = BE_BYTE0 << pos_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      // Non-one-hot width codes cannot be serviced; report them as misaligned.
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store unit: alignment check, lane steering, req/ack memory handshake.
// Latency: 1 cycle for non-memory/misaligned ops; >=3 cycles (accept, REQ, RESP) for memory ops.
// Backpressure: in_ready only in IDLE; mem_req held until mem_ack or TIMEOUT cycles elapse.
// Ports: in_* request from EX/MEM, mem (interface master) to data memory, out_* to MEM/WB.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [2:0]  in_width_sign,
  input  logic        in_sign,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  dmem_access_unit_if.master mem,
  output logic        out_valid,
  output logic        out_load,
  output logic [31:0] out_dmem_data,
  output logic [1:0]  out_pos,
  output logic [2:0]  out_width_sign,
  output logic        out_sign,
  output logic [4:0]  out_rd,
  output logic        out_misalign,
  output logic        out_bus_err
);

  state_e    state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  mem_cmd_t  cmd_q, cmd_d;
  req_info_t info_q, info_d;
  out_t      out_q, out_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic        lane_misalign;
  logic        accept;
  logic        is_mem;
  req_info_t   cur_info;

  store_lane_gen u_lane (
    .width_i    (in_width_sign),
    .pos_i      (in_addr[1:0]),
    .wdata_i    (in_wdata),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .misalign_o (lane_misalign)
  );

  // Reset is asynchronous, so state already reads IDLE during rst; gate explicitly.
  assign in_ready = (state_q == ST_IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign is_mem   = in_load || in_store;

  always_comb begin
    cur_info.load  = in_load;
    cur_info.pos   = in_addr[1:0];
    cur_info.width = in_width_sign;
    cur_info.sign  = in_sign;
    cur_info.rd    = in_rd;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_d        = cmd_q;
    info_d       = info_q;
    out_d        = out_q;
    out_d.valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            out_d = make_out(cur_info, 32'h0, 1'b0, 1'b0);
          end else if (lane_misalign) begin
            out_d = make_out(cur_info, 32'h0, 1'b1, 1'b0);
          end else begin
            cmd_d.req   = 1'b1;
            cmd_d.we    = in_store && !in_load;  // load wins when both are set
            cmd_d.be    = lane_be;
            cmd_d.addr  = {in_addr[31:2], 2'b00};
            cmd_d.wdata = lane_wdata;
            info_d      = cur_info;
            cnt_d       = '0;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // An ack on the final allowed cycle still completes normally.
        if (mem.mem_ack) begin
          cmd_d.req = 1'b0;
          out_d     = make_out(info_q, info_q.load ? mem.mem_rdata : 32'h0, 1'b0, 1'b0);
          state_d   = ST_RESP;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          cmd_d.req = 1'b0;
          out_d     = make_out(info_q, 32'h0, 1'b0, 1'b1);
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      info_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      info_q  <= info_d;
      out_q   <= out_d;
    end
  end

  assign mem.mem_req   = cmd_q.req;
  assign mem.mem_we    = cmd_q.we;
  assign mem.mem_be    = cmd_q.be;
  assign mem.mem_addr  = cmd_q.addr;
  assign mem.mem_wdata = cmd_q.wdata;

  assign out_valid      = out_q.valid;
  assign out_load       = out_q.load;
  assign out_dmem_data  = out_q.dmem_data;
  assign out_pos        = out_q.pos;
  assign out_width_sign = out_q.width;
  assign out_sign       = out_q.sign;
  assign out_rd         = out_q.rd;
  assign out_misalign   = out_q.misalign;
  assign out_bus_err    = out_q.bus_err;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed vector table plus
// timeout, late-ack and mid-transaction reset sequences.
// A second instance with TIMEOUT=4 exercises the bus-error path.
module tb_dmem_access_unit;

  logic        clk;
  logic        rst;
  logic        in_valid, t_in_valid;
  logic        in_ready, t_in_ready;
  logic        in_load, in_store, in_sign;
  logic [2:0]  in_width_sign;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd;

  logic        out_valid, out_load, out_sign, out_misalign, out_bus_err;
  logic [31:0] out_dmem_data;
  logic [1:0]  out_pos;
  logic [2:0]  out_width_sign;
  logic [4:0]  out_rd;

  logic        t_out_valid, t_out_load, t_out_sign, t_out_misalign, t_out_bus_err;
  logic [31:0] t_out_dmem_data;
  logic [1:0]  t_out_pos;
  logic [2:0]  t_out_width_sign;
  logic [4:0]  t_out_rd;

  int checks   = 0;
  int failures = 0;

  dmem_access_unit_if m_if ();
  dmem_access_unit_if t_if ();

  dmem_access_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_store(in_store), .in_width_sign(in_width_sign),
    .in_sign(in_sign), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem(m_if),
    .out_valid(out_valid), .out_load(out_load), .out_dmem_data(out_dmem_data),
    .out_pos(out_pos), .out_width_sign(out_width_sign), .out_sign(out_sign),
    .out_rd(out_rd), .out_misalign(out_misalign), .out_bus_err(out_bus_err)
  );

  dmem_access_unit #(.TIMEOUT(4)) dut_t (
    .clk(clk), .rst(rst), .in_valid(t_in_valid), .in_ready(t_in_ready),
    .in_load(in_load), .in_store(in_store), .in_width_sign(in_width_sign),
    .in_sign(in_sign), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem(t_if),
    .out_valid(t_out_valid), .out_load(t_out_load), .out_dmem_data(t_out_dmem_data),
    .out_pos(t_out_pos), .out_width_sign(t_out_width_sign), .out_sign(t_out_sign),
    .out_rd(t_out_rd), .out_misalign(t_out_misalign), .out_bus_err(t_out_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ld;
    logic        st;
    logic [2:0]  w;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  rd;
    int          dly;    // REQ cycles without ack before the ack cycle
    logic [31:0] rdata;
    logic        mem;    // expect memory traffic
    logic        mis;
    logic        we;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic [31:0] dmem;
  } vec_t;

  vec_t v [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t);
    @(negedge clk);
    chk({t.name, "_in_ready_idle"}, 32'(in_ready), 32'h1);
    in_load       = t.ld;
    in_store      = t.st;
    in_width_sign = t.w;
    in_sign       = t.sg;
    in_addr       = t.addr;
    in_wdata      = t.wd;
    in_rd         = t.rd;
    in_valid      = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_load  = 1'b0;
    in_store = 1'b0;
    @(negedge clk);
    if (t.mem) begin
      // First REQ cycle
      chk({t.name, "_mem_req"},   32'(m_if.mem_req), 32'h1);
      chk({t.name, "_mem_we"},    32'(m_if.mem_we), 32'(t.we));
      chk({t.name, "_mem_be"},    32'(m_if.mem_be), 32'(t.be));
      chk({t.name, "_mem_addr"},  m_if.mem_addr, t.maddr);
      chk({t.name, "_mem_wdata"}, m_if.mem_wdata, t.mwd);
      chk({t.name, "_in_ready_req"}, 32'(in_ready), 32'h0);
      for (int k = 0; k < t.dly; k++) begin
        @(negedge clk);
        chk({t.name, "_req_held"}, {m_if.mem_req, m_if.mem_be, m_if.mem_addr[26:0]},
            {1'b1, t.be, t.maddr[26:0]});
        chk({t.name, "_no_early_valid"}, 32'(out_valid), 32'h0);
      end
      m_if.mem_ack   = 1'b1;
      m_if.mem_rdata = t.rdata;
      @(posedge clk);
      #1;
      m_if.mem_ack   = 1'b0;
      m_if.mem_rdata = 32'h0;
      @(negedge clk);
      // RESP cycle
      chk({t.name, "_in_ready_resp"}, 32'(in_ready), 32'h0);
      chk({t.name, "_req_dropped"},   32'(m_if.mem_req), 32'h0);
      chk({t.name, "_out_load"},      32'(out_load), 32'(t.ld));
      chk({t.name, "_out_dmem"},      out_dmem_data, t.dmem);
      chk({t.name, "_out_pos"},       32'(out_pos), 32'(t.addr[1:0]));
      chk({t.name, "_out_width"},     32'(out_width_sign), 32'(t.w));
      chk({t.name, "_out_sign"},      32'(out_sign), 32'(t.sg));
    end else begin
      chk({t.name, "_no_mem_req"}, 32'(m_if.mem_req), 32'h0);
      if (!t.mis) chk({t.name, "_out_load"}, 32'(out_load), 32'h0);
    end
    chk({t.name, "_out_valid"},    32'(out_valid), 32'h1);
    chk({t.name, "_out_rd"},       32'(out_rd), 32'(t.rd));
    chk({t.name, "_out_misalign"}, 32'(out_misalign), 32'(t.mis));
    chk({t.name, "_out_bus_err"},  32'(out_bus_err), 32'h0);
    @(negedge clk);
    chk({t.name, "_valid_pulse"}, 32'(out_valid), 32'h0);
    chk({t.name, "_ready_after"}, 32'(in_ready), 32'h1);
  endtask

  initial begin
    int req_cnt;
    int vld_cnt;
    logic seen;

    // name ld st w sg addr wdata rd dly rdata | mem mis we be maddr mwdata dmem
    v[0]  = '{"sw",    1'b0, 1'b1, 3'b001, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 5'd3,  0, 32'h0,
              1'b1, 1'b0, 1'b1, 4'b1111, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0};
    v[1]  = '{"sb",    1'b0, 1'b1, 3'b100, 1'b0, 32'h0000_2003, 32'h0000_00A5, 5'd4,  2, 32'h0000_1234,
              1'b1, 1'b0, 1'b1, 4'b1000, 32'h0000_2000, 32'hA5A5_A5A5, 32'h0};
    v[2]  = '{"lh",    1'b1, 1'b0, 3'b010, 1'b1, 32'h0000_3002, 32'h0,         5'd5,  4, 32'h8001_1234,
              1'b1, 1'b0, 1'b0, 4'b1100, 32'h0000_3000, 32'h0,         32'h8001_1234};
    v[3]  = '{"lw_mis", 1'b1, 1'b0, 3'b001, 1'b0, 32'h0000_0006, 32'h0,        5'd6,  0, 32'h0,
              1'b0, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0};
    v[4]  = '{"lh_mis", 1'b1, 1'b0, 3'b010, 1'b1, 32'h0000_0001, 32'h0,        5'd7,  0, 32'h0,
              1'b0, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0};
    v[5]  = '{"nop",   1'b0, 1'b0, 3'b001, 1'b0, 32'h0000_0013, 32'h0000_0055, 5'd8,  0, 32'h0,
              1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0};
    v[6]  = '{"lb",    1'b1, 1'b0, 3'b100, 1'b1, 32'h0000_4001, 32'h0,         5'd9,  1, 32'hCAFE_F00D,
              1'b1, 1'b0, 1'b0, 4'b0010, 32'h0000_4000, 32'h0,         32'hCAFE_F00D};
    v[7]  = '{"sh",    1'b0, 1'b1, 3'b010, 1'b0, 32'h0000_5000, 32'hFFFF_BEEF, 5'd10, 0, 32'h0,
              1'b1, 1'b0, 1'b1, 4'b0011, 32'h0000_5000, 32'hBEEF_BEEF, 32'h0};
    v[8]  = '{"bad_w", 1'b1, 1'b0, 3'b011, 1'b0, 32'h0000_0010, 32'h0,         5'd11, 0, 32'h0,
              1'b0, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0};
    v[9]  = '{"ldst",  1'b1, 1'b1, 3'b001, 1'b0, 32'h0000_6008, 32'h0000_0099, 5'd12, 3, 32'h1111_2222,
              1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_6008, 32'h0000_0099, 32'h1111_2222};
    v[10] = '{"sb0",   1'b0, 1'b1, 3'b100, 1'b0, 32'h0000_7000, 32'h1234_5677, 5'd13, 0, 32'h0,
              1'b1, 1'b0, 1'b1, 4'b0001, 32'h0000_7000, 32'h7777_7777, 32'h0};

    rst = 1'b1;
    in_valid = 1'b0; t_in_valid = 1'b0;
    in_load = 1'b0; in_store = 1'b0; in_sign = 1'b0;
    in_width_sign = 3'b001; in_addr = '0; in_wdata = '0; in_rd = '0;
    m_if.mem_ack = 1'b0; m_if.mem_rdata = '0;
    t_if.mem_ack = 1'b0; t_if.mem_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(in_ready), 32'h0);
    chk("rst_mem_req",   32'(m_if.mem_req), 32'h0);
    chk("rst_mem_be",    32'(m_if.mem_be), 32'h0);
    chk("rst_mem_addr",  m_if.mem_addr, 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_dmem",  out_dmem_data, 32'h0);
    chk("rst_out_flags", 32'({out_misalign, out_bus_err, out_load}), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'h1);

    for (int i = 0; i < 11; i++) run_vec(v[i]);

    // Timeout on the TIMEOUT=4 instance: mem_req for exactly 4 cycles, then bus error
    @(negedge clk);
    chk("to_in_ready", 32'(t_in_ready), 32'h1);
    in_load = 1'b1; in_width_sign = 3'b001; in_addr = 32'h0000_7100; in_rd = 5'd14; in_sign = 1'b0;
    t_in_valid = 1'b1;
    @(posedge clk);
    #1;
    t_in_valid = 1'b0; in_load = 1'b0;
    req_cnt = 0; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (t_if.mem_req) req_cnt++;
      if (t_out_valid) begin
        seen = 1'b1;
        chk("to_bus_err",  32'(t_out_bus_err), 32'h1);
        chk("to_misalign", 32'(t_out_misalign), 32'h0);
        chk("to_rd",       32'(t_out_rd), 32'd14);
        chk("to_load",     32'(t_out_load), 32'h1);
        chk("to_dmem",     t_out_dmem_data, 32'h0);
      end
    end
    chk("to_valid_seen", 32'(seen), 32'h1);
    chk("to_req_cycles", 32'(req_cnt), 32'd4);
    @(negedge clk);
    chk("to_back_idle", 32'(t_in_ready), 32'h1);
    t_if.mem_ack = 1'b1; t_if.mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    t_if.mem_ack = 1'b0;
    vld_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (t_out_valid) vld_cnt++;
    end
    chk("to_late_ack_ignored", 32'(vld_cnt), 32'h0);

    // Reset pulsed during REQ
    @(negedge clk);
    in_load = 1'b1; in_width_sign = 3'b001; in_addr = 32'h0000_8000; in_rd = 5'd15;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_load = 1'b0;
    @(negedge clk);
    chk("rr_req_before", 32'(m_if.mem_req), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("rr_req_async_drop", 32'(m_if.mem_req), 32'h0);
    chk("rr_in_ready_low",   32'(in_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    vld_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out_valid) vld_cnt++;
    end
    chk("rr_no_valid", 32'(vld_cnt), 32'h0);
    run_vec(v[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule
